// File: rtl/systolic_tile_loader.sv
// Tile loader for a 2x2 systolic array: packs a byte-serial operand stream into activation/weight words.
// Latency: last operand byte accepted at edge t -> tile on outputs from edge t+1 (idle case); strobe RESULT_LAT cycles after first issue.
// Backpressure: in_ready drops while a complete tile waits in the fill buffer; it returns the cycle after that tile moves to the outputs.
//
// Ports:
//   clk, reset (async, active-high)
//   in_data / in_valid / in_ready   byte-serial operands: 4 activations then 4 weights, element e at [e*8 +: 8]
//   flush                           synchronous soft clear of fill buffer, issue state and strobe pipe
//   activation_stream, weight_stream, tile_valid   tile currently presented to the array
//   result_strobe                   one-cycle pulse per tile, RESULT_LAT cycles after its first issue cycle
//   tile_count, stall_count         only with LOADER_STATS_EN defined: saturating tile / fill-wait counters
module systolic_tile_loader #(
   parameter int HOLD_CYCLES = 3,
   parameter int RESULT_LAT  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [31:0] activation_stream,
   output logic [31:0] weight_stream,
   output logic        tile_valid,
   output logic        result_strobe
`ifdef LOADER_STATS_EN
   ,
   output logic [15:0] tile_count,
   output logic [15:0] stall_count
`endif
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   ctr, ctr_n;
   logic            load;
   logic            clr_out;

   logic [2:0]      idx;
   logic            full;
   logic [31:0]     act_buf;
   logic [31:0]     wgt_buf;
   logic [RESULT_LAT:0] strobe_pipe;

   // full is a flop, so in_ready has no combinational path from any input.
   assign in_ready      = ~full;
   assign tile_valid    = (state == ISSUE);
   assign result_strobe = strobe_pipe[RESULT_LAT];

   // Fill side. A load only happens while full, and bytes are only taken while
   // not full, so the two never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         full    <= 1'b0;
         act_buf <= '0;
         wgt_buf <= '0;
      end else if (flush) begin
         idx  <= '0;
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b0;
      end else if (in_valid && !full) begin
         if (idx[2])
            wgt_buf[{idx[1:0], 3'b000} +: 8] <= in_data;
         else
            act_buf[{idx[1:0], 3'b000} +: 8] <= in_data;
         idx <= idx + 3'd1;
         if (idx == 3'd7)
            full <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ctr   <= '0;
      end else begin
         state <= state_n;
         ctr   <= ctr_n;
      end
   end

   always_comb begin
      state_n = state;
      ctr_n   = ctr;
      load    = 1'b0;
      clr_out = 1'b0;
      if (flush) begin
         state_n = IDLE;
         clr_out = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (full) begin
                  load    = 1'b1;
                  state_n = ISSUE;
                  ctr_n   = HOLD_LAST;
               end
            end
            ISSUE: begin
               if (ctr != '0) begin
                  ctr_n = ctr - CW'(1);
               end else if (full) begin
                  // Next tile already waiting: swap it in with no idle cycle.
                  load  = 1'b1;
                  ctr_n = HOLD_LAST;
               end else begin
                  state_n = IDLE;
                  clr_out = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         activation_stream <= '0;
         weight_stream     <= '0;
      end else if (clr_out) begin
         activation_stream <= '0;
         weight_stream     <= '0;
      end else if (load) begin
         activation_stream <= act_buf;
         weight_stream     <= wgt_buf;
      end
   end

   // Bit k is set in the k-th cycle after a tile's first issue cycle, so
   // overlapping tiles each produce their own pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         strobe_pipe <= '0;
      else if (flush)
         strobe_pipe <= '0;
      else
         strobe_pipe <= {strobe_pipe[RESULT_LAT-1:0], load};
   end

`ifdef LOADER_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tile_count  <= '0;
         stall_count <= '0;
      end else begin
         if (load && tile_count != 16'hFFFF)
            tile_count <= tile_count + 16'd1;
         if (!flush && full && state == ISSUE && ctr != '0 && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_tile_loader.sv
// Bench for systolic_tile_loader: directed tiles, expected words and strobe times checked by a monitor.
// Latency: not applicable.
// Backpressure: stimulus holds in_valid until in_ready is seen.
module tb_systolic_tile_loader;

   localparam int HOLD = 12;
   localparam int RL   = 3;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] activation_stream;
   logic [31:0] weight_stream;
   logic        tile_valid;
   logic        result_strobe;
`ifdef LOADER_STATS_EN
   logic [15:0] tile_count;
   logic [15:0] stall_count;
`endif

   systolic_tile_loader #(.HOLD_CYCLES(HOLD), .RESULT_LAT(RL)) dut (
      .clk               (clk),
      .reset             (reset),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .flush             (flush),
      .activation_stream (activation_stream),
      .weight_stream     (weight_stream),
      .tile_valid        (tile_valid),
      .result_strobe     (result_strobe)
`ifdef LOADER_STATS_EN
      ,
      .tile_count        (tile_count),
      .stall_count       (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [63:0] exp_q[$];    // {activation, weight} per expected tile
   int          start_q[$];  // first-issue cycle of each tile awaiting its strobe

   int  run_len     = 0;
   int  streak      = 0;
   int  last_streak = 0;
   bit  prev_vld    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event occurred / missing contrary to requirement (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops expected tiles when a new tile appears and checks strobe timing.
   always @(negedge clk) begin
      if (reset) begin
         start_q.delete();
         run_len  = 0;
         streak   = 0;
         prev_vld = 1'b0;
      end else begin
         if (tile_valid) begin
            if (!prev_vld || run_len == HOLD) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_tile");
               end else begin
                  logic [63:0] e;
                  e = exp_q.pop_front();
                  check("tile_act", {32'h0, activation_stream}, {32'h0, e[63:32]});
                  check("tile_wgt", {32'h0, weight_stream}, {32'h0, e[31:0]});
               end
               start_q.push_back(cyc);
               run_len = 1;
            end else begin
               run_len++;
            end
            streak++;
         end else begin
            if (prev_vld) begin
               check("hold_len", run_len, HOLD);
               last_streak = streak;
            end
            streak  = 0;
            run_len = 0;
         end
         if (result_strobe) begin
            if (start_q.size() == 0) begin
               fail("spurious_strobe");
            end else begin
               int s;
               s = start_q.pop_front();
               check("strobe_time", cyc, s + RL);
            end
         end
         prev_vld = tile_valid;
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit gap);
      int g;
      g = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) fail("accept_timeout");
      @(posedge clk);
      if (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_tile(input logic [31:0] a, input logic [31:0] w, input bit gap);
      logic [7:0] b;
      exp_q.push_back({a, w});
      for (int e = 0; e < 8; e++) begin
         b = (e < 4) ? a[e*8 +: 8] : w[(e-4)*8 +: 8];
         send_byte(b, gap);
      end
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      @(negedge clk);
      while (tile_valid && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (tile_valid) fail("idle_timeout");
      repeat (RL + 3) @(negedge clk);
   endtask

   // Called at the negedge just after the 8th byte's accepting edge.
   task automatic check_first_latency(input string tag);
      check({tag, "_vld_wait"}, tile_valid, 1'b0);
      check({tag, "_rdy_full"}, in_ready, 1'b0);
      @(negedge clk);
      check({tag, "_vld_issue"}, tile_valid, 1'b1);
      check({tag, "_rdy_back"}, in_ready, 1'b1);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      flush    = 1'b0;
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_act", activation_stream, 32'h0);
      check("rst_wgt", weight_stream, 32'h0);
      check("rst_tile_valid", tile_valid, 1'b0);
      check("rst_strobe", result_strobe, 1'b0);
`ifdef LOADER_STATS_EN
      check("rst_tile_count", tile_count, 16'h0);
      check("rst_stall_count", stall_count, 16'h0);
`endif
      @(negedge clk);
      #2 reset = 1'b0;

      // T1: back-to-back bytes 01..08
      send_tile(32'h04030201, 32'h08070605, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check_first_latency("t1");
      check("t1_act", activation_stream, 32'h04030201);
      check("t1_wgt", weight_stream, 32'h08070605);
      wait_idle();

      // T3: in_valid toggling each cycle
      send_tile(32'h04030201, 32'h08070605, 1'b1);
      check_first_latency("t3");
      wait_idle();

      // T4: partial fill, flush (with a byte offered that cycle), then a clean tile
      for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b0);
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("t4_rdy_after_flush", in_ready, 1'b1);
      check("t4_vld_after_flush", tile_valid, 1'b0);
      send_tile(32'hADACABAA, 32'hB1B0AFAE, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check_first_latency("t4");
      wait_idle();

      // T5: reset in the second issue cycle
      send_tile(32'h55443322, 32'h99887766, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      begin
         int g;
         g = 0;
         while (!tile_valid && g < 20) begin
            @(negedge clk);
            g++;
         end
         if (!tile_valid) fail("t5_issue_timeout");
      end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("t5_act", activation_stream, 32'h0);
      check("t5_wgt", weight_stream, 32'h0);
      check("t5_tile_valid", tile_valid, 1'b0);
      check("t5_in_ready", in_ready, 1'b1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      repeat (RL + 4) @(negedge clk);
      check("t5_strobe_quiet", result_strobe, 1'b0);
`ifdef LOADER_STATS_EN
      check("t5_tile_count", tile_count, 16'h0);
`endif

      // T2/T6: three tiles streamed continuously; fills overlap holds
      send_tile(32'hA4A3A2A1, 32'hB4B3B2B1, 1'b0);
      send_tile(32'hC4C3C2C1, 32'hD4D3D2D1, 1'b0);
      send_tile(32'hE4E3E2E1, 32'hF4F3F2F1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      check("t2_no_gap_streak", last_streak, 3 * HOLD);
`ifdef LOADER_STATS_EN
      check("t6_tile_count", tile_count, 16'd3);
      check("t6_stall_count", stall_count, 16'd6);
`endif

      check("exp_tiles_left", exp_q.size(), 0);
      check("strobes_left", start_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
